// File: rtl/datamover_bist_ctrl.sv
// rtl/datamover_bist_ctrl.sv - DataMover/BRAM BIST: write a counting pattern, read it back, check data and status.
// Runs NUM_BURSTS write/read-back pairs per start and reports an error count and pass flag.
module datamover_bist_ctrl #(
  parameter int          DATA_W          = 32,
  parameter logic [31:0] BASE_ADDR       = 32'hC000_0000,
  parameter int          WORDS_PER_BURST = 128,
  parameter int          NUM_BURSTS      = 4,
  parameter logic [3:0]  TAG             = 4'hE
) (
  input  logic                clk_in1,
  input  logic                aresetn,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [15:0]         err_count,
  output logic [71:0]         s2mm_cmd_tdata,
  output logic                s2mm_cmd_tvalid,
  input  logic                s2mm_cmd_tready,
  output logic [DATA_W-1:0]   s2mm_tdata,
  output logic [DATA_W/8-1:0] s2mm_tkeep,
  output logic                s2mm_tlast,
  output logic                s2mm_tvalid,
  input  logic                s2mm_tready,
  input  logic [7:0]          s2mm_sts_tdata,
  input  logic                s2mm_sts_tvalid,
  output logic                s2mm_sts_tready,
  output logic [71:0]         mm2s_cmd_tdata,
  output logic                mm2s_cmd_tvalid,
  input  logic                mm2s_cmd_tready,
  input  logic [DATA_W-1:0]   mm2s_tdata,
  input  logic                mm2s_tlast,
  input  logic                mm2s_tvalid,
  output logic                mm2s_tready,
  input  logic [7:0]          mm2s_sts_tdata,
  input  logic                mm2s_sts_tvalid,
  output logic                mm2s_sts_tready
);

  localparam int                BEAT_W    = $clog2(WORDS_PER_BURST + 1);
  localparam logic [22:0]       BTT       = 23'(WORDS_PER_BURST * DATA_W / 8);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_BURST - 1);
  localparam logic [15:0]       LAST_BURST = 16'(NUM_BURSTS - 1);
  localparam logic [31:0]       WPB32     = 32'(WORDS_PER_BURST);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_CMD, S_WR_DATA, S_WR_STS, S_RD_CMD, S_RD_DATA, S_RD_STS, S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       burst_q, burst_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       word_base_q, word_base_d;
  logic [15:0]       err_q, err_d;
  logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic              wcmd_valid_q, wcmd_valid_d, wdata_valid_q, wdata_valid_d;
  logic              wsts_ready_q, wsts_ready_d;
  logic              rcmd_valid_q, rcmd_valid_d, rdata_ready_q, rdata_ready_d;
  logic              rsts_ready_q, rsts_ready_d;

  logic [31:0] pattern;
  logic [71:0] cmd_word;
  logic        rd_data_err, rd_last_err, wsts_bad, rsts_bad;
  logic        unused_sts_bits;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] n);
    logic [16:0] s;
    s = {1'b0, a} + {15'b0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Data pattern and command word depend only on flops, so nothing from a tready reaches a tvalid or tdata.
  assign pattern     = word_base_q + 32'(beat_q);
  assign cmd_word    = {4'h0, TAG, addr_q, 1'b0, 1'b1, 6'h0, 1'b1, BTT};
  assign rd_data_err = (mm2s_tdata != DATA_W'(pattern));
  assign rd_last_err = (mm2s_tlast != (beat_q == LAST_BEAT));
  assign wsts_bad    = !s2mm_sts_tdata[7] || (s2mm_sts_tdata[3:0] != TAG);
  assign rsts_bad    = !mm2s_sts_tdata[7] || (mm2s_sts_tdata[3:0] != TAG);
  assign unused_sts_bits = ^{s2mm_sts_tdata[6:4], mm2s_sts_tdata[6:4]};

  always_comb begin
    state_d       = state_q;
    burst_d       = burst_q;
    beat_d        = beat_q;
    addr_d        = addr_q;
    word_base_d   = word_base_q;
    err_d         = err_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    pass_d        = pass_q;
    wcmd_valid_d  = wcmd_valid_q;
    wdata_valid_d = wdata_valid_q;
    wsts_ready_d  = wsts_ready_q;
    rcmd_valid_d  = rcmd_valid_q;
    rdata_ready_d = rdata_ready_q;
    rsts_ready_d  = rsts_ready_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d        = 16'h0;
          pass_d       = 1'b0;
          busy_d       = 1'b1;
          burst_d      = 16'h0;
          beat_d       = '0;
          addr_d       = BASE_ADDR;
          word_base_d  = 32'h0;
          wcmd_valid_d = 1'b1;
          state_d      = S_WR_CMD;
        end
      end
      S_WR_CMD: begin
        if (wcmd_valid_q && s2mm_cmd_tready) begin
          wcmd_valid_d  = 1'b0;
          wdata_valid_d = 1'b1;
          beat_d        = '0;
          state_d       = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        if (wdata_valid_q && s2mm_tready) begin
          if (beat_q == LAST_BEAT) begin
            wdata_valid_d = 1'b0;
            wsts_ready_d  = 1'b1;
            beat_d        = '0;
            state_d       = S_WR_STS;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      S_WR_STS: begin
        if (wsts_ready_q && s2mm_sts_tvalid) begin
          err_d        = sat_add(err_q, {1'b0, wsts_bad});
          wsts_ready_d = 1'b0;
          rcmd_valid_d = 1'b1;
          state_d      = S_RD_CMD;
        end
      end
      S_RD_CMD: begin
        if (rcmd_valid_q && mm2s_cmd_tready) begin
          rcmd_valid_d  = 1'b0;
          rdata_ready_d = 1'b1;
          beat_d        = '0;
          state_d       = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (rdata_ready_q && mm2s_tvalid) begin
          err_d = sat_add(err_q, {1'b0, rd_data_err} + {1'b0, rd_last_err});
          if (beat_q == LAST_BEAT) begin
            rdata_ready_d = 1'b0;
            rsts_ready_d  = 1'b1;
            state_d       = S_RD_STS;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      S_RD_STS: begin
        if (rsts_ready_q && mm2s_sts_tvalid) begin
          err_d        = sat_add(err_q, {1'b0, rsts_bad});
          rsts_ready_d = 1'b0;
          if (burst_q == LAST_BURST) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            pass_d  = (err_d == 16'h0);
            state_d = S_FIN;
          end else begin
            burst_d      = burst_q + 16'd1;
            addr_d       = addr_q + {9'h0, BTT};
            word_base_d  = word_base_q + WPB32;
            wcmd_valid_d = 1'b1;
            state_d      = S_WR_CMD;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in1 or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= S_IDLE;
      burst_q       <= 16'h0;
      beat_q        <= '0;
      addr_q        <= BASE_ADDR;
      word_base_q   <= 32'h0;
      err_q         <= 16'h0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      wcmd_valid_q  <= 1'b0;
      wdata_valid_q <= 1'b0;
      wsts_ready_q  <= 1'b0;
      rcmd_valid_q  <= 1'b0;
      rdata_ready_q <= 1'b0;
      rsts_ready_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      burst_q       <= burst_d;
      beat_q        <= beat_d;
      addr_q        <= addr_d;
      word_base_q   <= word_base_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      wcmd_valid_q  <= wcmd_valid_d;
      wdata_valid_q <= wdata_valid_d;
      wsts_ready_q  <= wsts_ready_d;
      rcmd_valid_q  <= rcmd_valid_d;
      rdata_ready_q <= rdata_ready_d;
      rsts_ready_q  <= rsts_ready_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign s2mm_cmd_tdata  = cmd_word;
  assign s2mm_cmd_tvalid = wcmd_valid_q;
  assign s2mm_tdata      = DATA_W'(pattern);
  assign s2mm_tkeep      = '1;
  assign s2mm_tlast      = (beat_q == LAST_BEAT);
  assign s2mm_tvalid     = wdata_valid_q;
  assign s2mm_sts_tready = wsts_ready_q;
  assign mm2s_cmd_tdata  = cmd_word;
  assign mm2s_cmd_tvalid = rcmd_valid_q;
  assign mm2s_tready     = rdata_ready_q;
  assign mm2s_sts_tready = rsts_ready_q;

endmodule

// File: tb/tb_datamover_bist_ctrl.sv
// tb/tb_datamover_bist_ctrl.sv - randomized scoreboard bench for datamover_bist_ctrl.
module tb_datamover_bist_ctrl;
  localparam int          DW   = 64;
  localparam int          WPB  = 16;
  localparam int          NB   = 4;
  localparam logic [31:0] BASE = 32'hFFFF_FF00;
  localparam logic [3:0]  TAG  = 4'hE;
  localparam int          BTT  = WPB * DW / 8;

  logic clk_in1 = 1'b0;
  logic aresetn, start, busy, done, pass;
  logic [15:0] err_count;
  logic [71:0] s2mm_cmd_tdata, mm2s_cmd_tdata;
  logic s2mm_cmd_tvalid, s2mm_cmd_tready, mm2s_cmd_tvalid, mm2s_cmd_tready;
  logic [DW-1:0] s2mm_tdata, mm2s_tdata;
  logic [DW/8-1:0] s2mm_tkeep;
  logic s2mm_tlast, s2mm_tvalid, s2mm_tready, mm2s_tlast, mm2s_tvalid, mm2s_tready;
  logic [7:0] s2mm_sts_tdata, mm2s_sts_tdata;
  logic s2mm_sts_tvalid, s2mm_sts_tready, mm2s_sts_tvalid, mm2s_sts_tready;

  datamover_bist_ctrl #(.DATA_W(DW), .BASE_ADDR(BASE), .WORDS_PER_BURST(WPB),
                        .NUM_BURSTS(NB), .TAG(TAG)) dut (
    .clk_in1(clk_in1), .aresetn(aresetn), .start(start), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count),
    .s2mm_cmd_tdata(s2mm_cmd_tdata), .s2mm_cmd_tvalid(s2mm_cmd_tvalid), .s2mm_cmd_tready(s2mm_cmd_tready),
    .s2mm_tdata(s2mm_tdata), .s2mm_tkeep(s2mm_tkeep), .s2mm_tlast(s2mm_tlast),
    .s2mm_tvalid(s2mm_tvalid), .s2mm_tready(s2mm_tready),
    .s2mm_sts_tdata(s2mm_sts_tdata), .s2mm_sts_tvalid(s2mm_sts_tvalid), .s2mm_sts_tready(s2mm_sts_tready),
    .mm2s_cmd_tdata(mm2s_cmd_tdata), .mm2s_cmd_tvalid(mm2s_cmd_tvalid), .mm2s_cmd_tready(mm2s_cmd_tready),
    .mm2s_tdata(mm2s_tdata), .mm2s_tlast(mm2s_tlast), .mm2s_tvalid(mm2s_tvalid), .mm2s_tready(mm2s_tready),
    .mm2s_sts_tdata(mm2s_sts_tdata), .mm2s_sts_tvalid(mm2s_sts_tvalid), .mm2s_sts_tready(mm2s_sts_tready)
  );

  always #5 clk_in1 = ~clk_in1;

  typedef struct { logic [DW-1:0] data; logic last; } wbeat_t;
  typedef struct { logic [DW-1:0] data; logic last; logic fin; int burst; } rbeat_t;
  typedef struct { logic [15:0] err; logic pass; } res_t;

  logic [71:0] exp_wcmd_q[$], exp_rcmd_q[$];
  wbeat_t      exp_wdata_q[$];
  rbeat_t      rd_src_q[$];
  logic [7:0]  wsts_src_q[$], rsts_src_q[$];
  res_t        exp_res_q[$];

  int checks = 0, errors = 0;
  int wr_beats = 0, rd_cmds = 0, done_cnt = 0;
  int c_bad_b, c_bad_w, c_bad_bit, c_tl_b, c_tl_w;
  logic [7:0] c_wsts[NB], c_rsts[NB];
  bit stall = 0, skip_wsts = 0, early_phase = 0, last_pass = 0;
  bit wcmd_hold = 0, wdata_hold = 0, prev_done = 0;
  logic [71:0] wcmd_last;
  logic [DW:0] wdata_last;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] exp_cmd(input int b);
    logic [31:0] a;
    a = BASE + 32'(b * BTT);
    return {4'h0, TAG, a, 1'b0, 1'b1, 6'h0, 1'b1, 23'(BTT)};
  endfunction

  function automatic logic [DW-1:0] exp_beat(input int b, input int w);
    logic [31:0] v;
    v = 32'(b * WPB + w);
    return {{(DW-32){1'b0}}, v};
  endfunction

  function automatic int sts_bad(input logic [7:0] s);
    return (!s[7] || s[3:0] != TAG) ? 1 : 0;
  endfunction

  // Slave ready drivers: registered DUT valids are sampled on the falling edge.
  initial begin
    s2mm_cmd_tready = 0; mm2s_cmd_tready = 0; s2mm_tready = 0;
    forever begin
      @(posedge clk_in1); #1;
      s2mm_cmd_tready = stall ? 1'($urandom_range(1, 0)) : 1'b1;
      mm2s_cmd_tready = stall ? 1'($urandom_range(1, 0)) : 1'b1;
      s2mm_tready     = stall ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  end

  initial begin
    rbeat_t cur;
    bit took;
    cur = '{default: 0};
    mm2s_tvalid = 0; mm2s_tdata = '0; mm2s_tlast = 0;
    forever begin
      @(negedge clk_in1); took = mm2s_tvalid && mm2s_tready;
      @(posedge clk_in1); #1;
      if (!aresetn) mm2s_tvalid = 0;
      else begin
        if (took) begin
          mm2s_tvalid = 0;
          if (cur.fin) rsts_src_q.push_back(c_rsts[cur.burst]);
        end
        if (!mm2s_tvalid && rd_src_q.size() != 0 && (!stall || $urandom_range(1, 0) == 1)) begin
          cur = rd_src_q.pop_front();
          mm2s_tdata = cur.data; mm2s_tlast = cur.last; mm2s_tvalid = 1;
        end
      end
    end
  end

  initial begin
    bit took;
    s2mm_sts_tvalid = 0; s2mm_sts_tdata = '0;
    forever begin
      @(negedge clk_in1); took = s2mm_sts_tvalid && s2mm_sts_tready;
      @(posedge clk_in1); #1;
      if (!aresetn) s2mm_sts_tvalid = 0;
      else begin
        if (took) s2mm_sts_tvalid = 0;
        if (!s2mm_sts_tvalid && wsts_src_q.size() != 0 && (!stall || $urandom_range(1, 0) == 1)) begin
          s2mm_sts_tdata = wsts_src_q.pop_front(); s2mm_sts_tvalid = 1;
        end
      end
    end
  end

  initial begin
    bit took;
    mm2s_sts_tvalid = 0; mm2s_sts_tdata = '0;
    forever begin
      @(negedge clk_in1); took = mm2s_sts_tvalid && mm2s_sts_tready;
      @(posedge clk_in1); #1;
      if (!aresetn) mm2s_sts_tvalid = 0;
      else begin
        if (took) mm2s_sts_tvalid = 0;
        if (!mm2s_sts_tvalid && rsts_src_q.size() != 0 && (!stall || $urandom_range(1, 0) == 1)) begin
          mm2s_sts_tdata = rsts_src_q.pop_front(); mm2s_sts_tvalid = 1;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT completes a transfer or signals done.
  always @(negedge clk_in1) begin
    if (aresetn) begin
      if (wcmd_hold) chk("wcmd_stable", {s2mm_cmd_tvalid, s2mm_cmd_tdata}, {1'b1, wcmd_last});
      wcmd_hold = 0;
      if (s2mm_cmd_tvalid && s2mm_cmd_tready) begin
        chk("wcmd_expected", exp_wcmd_q.size() != 0, 1'b1);
        if (exp_wcmd_q.size() != 0) chk("wcmd", s2mm_cmd_tdata, exp_wcmd_q.pop_front());
      end else if (s2mm_cmd_tvalid) begin
        wcmd_hold = 1; wcmd_last = s2mm_cmd_tdata;
      end

      if (wdata_hold) chk("wdata_stable", {s2mm_tvalid, s2mm_tlast, s2mm_tdata}, {1'b1, wdata_last});
      wdata_hold = 0;
      if (s2mm_tvalid && s2mm_tready) begin
        wbeat_t e;
        chk("wdata_expected", exp_wdata_q.size() != 0, 1'b1);
        if (exp_wdata_q.size() != 0) begin
          e = exp_wdata_q.pop_front();
          chk("wdata", {s2mm_tkeep, s2mm_tlast, s2mm_tdata}, {{(DW/8){1'b1}}, e.last, e.data});
        end
        wr_beats++;
        if (wr_beats % WPB == 0 && wr_beats / WPB <= NB) begin
          if (skip_wsts) skip_wsts = 0;
          else wsts_src_q.push_back(c_wsts[wr_beats / WPB - 1]);
          early_phase = 0;
        end
      end else if (s2mm_tvalid) begin
        wdata_hold = 1; wdata_last = {s2mm_tlast, s2mm_tdata};
      end

      if (mm2s_cmd_tvalid && mm2s_cmd_tready) begin
        chk("rcmd_expected", exp_rcmd_q.size() != 0, 1'b1);
        if (exp_rcmd_q.size() != 0) chk("rcmd", mm2s_cmd_tdata, exp_rcmd_q.pop_front());
        if (rd_cmds < NB) begin
          for (int w = 0; w < WPB; w++) begin
            rbeat_t r;
            r.data = exp_beat(rd_cmds, w);
            if (rd_cmds == c_bad_b && w == c_bad_w) r.data[c_bad_bit] = ~r.data[c_bad_bit];
            r.last = (w == WPB - 1);
            if (rd_cmds == c_tl_b && w == c_tl_w) r.last = ~r.last;
            r.fin = (w == WPB - 1);
            r.burst = rd_cmds;
            rd_src_q.push_back(r);
          end
        end
        rd_cmds++;
      end

      if (early_phase) chk("sts_held_off", s2mm_sts_tready, 1'b0);
      if (!busy)
        chk("idle_quiet", {s2mm_cmd_tvalid, s2mm_tvalid, s2mm_sts_tready,
                           mm2s_cmd_tvalid, mm2s_tready, mm2s_sts_tready}, 6'b0);
      if (done) begin
        res_t r;
        chk("done_single", prev_done, 1'b0);
        chk("result_expected", exp_res_q.size() != 0, 1'b1);
        if (exp_res_q.size() != 0) begin
          r = exp_res_q.pop_front();
          chk("err_count", err_count, r.err);
          chk("pass", pass, r.pass);
        end
        done_cnt++;
      end
      prev_done = done;
    end else begin
      wcmd_hold = 0; wdata_hold = 0; prev_done = 0;
    end
  end

  task automatic cfg_clean();
    c_bad_b = -1; c_bad_w = 0; c_bad_bit = 0; c_tl_b = -1; c_tl_w = 0;
    for (int b = 0; b < NB; b++) begin c_wsts[b] = 8'h8E; c_rsts[b] = 8'h8E; end
  endtask

  task automatic cfg_random();
    logic [7:0] opts[6];
    opts = '{8'h8E, 8'h4E, 8'h83, 8'h0E, 8'hCE, 8'h8F};
    cfg_clean();
    c_bad_b = int'($urandom_range(NB - 1, 0)); c_bad_w = int'($urandom_range(WPB - 1, 0));
    c_bad_bit = int'($urandom_range(DW - 1, 0));
    if ($urandom_range(1, 0) == 1) begin
      c_tl_b = int'($urandom_range(NB - 1, 0)); c_tl_w = int'($urandom_range(WPB - 1, 0));
    end
    for (int b = 0; b < NB; b++) begin
      c_wsts[b] = opts[$urandom_range(5, 0)]; c_rsts[b] = opts[$urandom_range(5, 0)];
    end
  endtask

  task automatic issue_run(input bit extra_start, input bit early_sts);
    int e;
    res_t r;
    wr_beats = 0; rd_cmds = 0; e = 0;
    for (int b = 0; b < NB; b++) begin
      exp_wcmd_q.push_back(exp_cmd(b));
      exp_rcmd_q.push_back(exp_cmd(b));
      for (int w = 0; w < WPB; w++) begin
        exp_wdata_q.push_back('{exp_beat(b, w), w == WPB - 1});
        if (b == c_bad_b && w == c_bad_w) e++;
        if (b == c_tl_b && w == c_tl_w) e++;
      end
      e += sts_bad(c_wsts[b]) + sts_bad(c_rsts[b]);
    end
    r.err = (e > 65535) ? 16'hFFFF : 16'(e);
    r.pass = (e == 0);
    exp_res_q.push_back(r);
    last_pass = r.pass;
    if (early_sts) begin
      wsts_src_q.push_back(c_wsts[0]); skip_wsts = 1; early_phase = 1;
    end
    @(posedge clk_in1); #1 start = 1;
    @(posedge clk_in1); #1 start = 0;
    chk("first_cmd_latency", {busy, s2mm_cmd_tvalid}, 2'b11);
    if (extra_start) begin
      repeat (40) @(posedge clk_in1);
      #1 start = 1;
      @(posedge clk_in1); #1 start = 0;
    end
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 20000) begin @(posedge clk_in1); n++; end
    chk("run_completes", done_cnt >= target, 1'b1);
    @(negedge clk_in1);
    chk("queues_drained", exp_wcmd_q.size() + exp_rcmd_q.size() + exp_wdata_q.size() + rd_src_q.size()
        + wsts_src_q.size() + rsts_src_q.size() + exp_res_q.size(), 0);
    repeat (5) @(negedge clk_in1);
    chk("pass_held", pass, last_pass);
  endtask

  task automatic do_run(input bit stl, input bit extra_start, input bit early_sts);
    int target;
    stall = stl;
    target = done_cnt + 1;
    issue_run(extra_start, early_sts);
    wait_done(target);
  endtask

  initial begin
    int n;
    aresetn = 0; start = 0;
    cfg_clean();
    repeat (3) @(posedge clk_in1);
    #1;
    chk("reset_state", {s2mm_cmd_tvalid, s2mm_tvalid, s2mm_sts_tready, mm2s_cmd_tvalid, mm2s_tready,
                        mm2s_sts_tready, busy, done, pass, err_count}, 25'b0);
    @(negedge clk_in1); #1 aresetn = 1;

    cfg_clean(); do_run(0, 0, 0);
    cfg_clean(); do_run(1, 1, 1);
    cfg_clean(); c_bad_b = 1; c_bad_w = 5; c_bad_bit = 0; do_run(1, 0, 0);
    cfg_clean(); c_wsts[2] = 8'h4E; c_rsts[0] = 8'h83; do_run(1, 0, 0);
    cfg_clean(); c_tl_b = 3; c_tl_w = WPB - 1; c_bad_b = 3; c_bad_w = WPB - 1; c_bad_bit = 40;
    do_run(1, 0, 0);

    // Asynchronous reset in the middle of the first write burst.
    cfg_clean(); stall = 1;
    issue_run(0, 0);
    n = 0;
    while (wr_beats < 10 && n < 5000) begin @(negedge clk_in1); n++; end
    chk("reached_beat_10", wr_beats >= 10, 1'b1);
    #1 aresetn = 0;
    #1 chk("async_reset_outputs", {s2mm_cmd_tvalid, s2mm_tvalid, s2mm_sts_tready, mm2s_cmd_tvalid,
                                   mm2s_tready, mm2s_sts_tready, busy, done, err_count}, 24'b0);
    exp_wcmd_q.delete(); exp_rcmd_q.delete(); exp_wdata_q.delete(); rd_src_q.delete();
    wsts_src_q.delete(); rsts_src_q.delete(); exp_res_q.delete();
    wr_beats = 0; rd_cmds = 0; skip_wsts = 0; early_phase = 0;
    repeat (3) @(negedge clk_in1);
    #1 aresetn = 1;
    cfg_clean(); do_run(0, 0, 0);

    for (int i = 0; i < 3; i++) begin
      cfg_random(); do_run(1, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule
